// File: rtl/debounce_pkg.sv
// debounce_pkg: default count constants and released-level helper for the debounce array.
package debounce_pkg;
  localparam int DEF_CNT_W = 24;
  localparam logic [23:0] DEF_STABLE_CNT = 24'd1_000_000;
  localparam logic [23:0] DEF_LONG_CNT = 24'd10_000_000;
  function automatic logic released_level(input logic active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one key channel: synchroniser, stability filter, edge pulses and long-press pulse.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] STABLE_CNT = DEF_STABLE_CNT,
  parameter logic [CNT_W-1:0] LONG_CNT = DEF_LONG_CNT,
  parameter logic ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  logic [1:0] sync;
  logic s, cand, upd;
  logic [CNT_W-1:0] cnt, hold;
  assign s = ACTIVE_LOW ? ~sync[1] : sync[1];
  // Update decision uses the registered count, so a toggle on the saturating edge cannot cancel it.
  assign upd = (cnt == STABLE_CNT) && (level != cand);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= {2{released_level(ACTIVE_LOW)}};
      cand <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
      hold <= '0;
    end else begin
      sync <= {sync[0], raw};
      cand <= s;
      cnt <= (s != cand) ? '0 : (cnt == STABLE_CNT) ? cnt : cnt + 1'b1;
      level <= upd ? cand : level;
      press_pulse <= upd && cand;
      release_pulse <= upd && !cand;
      hold <= !level ? '0 : (hold == LONG_CNT) ? hold : hold + 1'b1;
      long_pulse <= level && (hold == LONG_CNT - 1'b1);
    end
endmodule

// File: rtl/debounce_array.sv
// debounce_array: N_KEYS independent debounced key channels with press/release/long-press pulses.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] STABLE_CNT = DEF_STABLE_CNT,
  parameter logic [CNT_W-1:0] LONG_CNT = DEF_LONG_CNT,
  parameter logic ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] long_o
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    debounce_chan #(
      .CNT_W(CNT_W),
      .STABLE_CNT(STABLE_CNT),
      .LONG_CNT(LONG_CNT),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .raw(key_i[i]),
      .level(key_o[i]),
      .press_pulse(press_o[i]),
      .release_pulse(release_o[i]),
      .long_pulse(long_o[i])
    );
  end
endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: directed checks of latency, glitch rejection, long press, multi-key and reset behaviour.
module tb_debounce_array;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] key_i, key_o, press_o, release_o, long_o;
  int checks = 0;
  int errors = 0;

  debounce_array #(
    .N_KEYS(2),
    .CNT_W(24),
    .STABLE_CNT(24'd4),
    .LONG_CNT(24'd10),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_i(key_i),
    .key_o(key_o),
    .press_o(press_o),
    .release_o(release_o),
    .long_o(long_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle_release;
    key_i = 2'b11;
    for (int t = 1; t <= 12; t++) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_i = 2'b11;
    #12;
    checks++;
    if ({key_o, press_o, release_o, long_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000", {key_o, press_o, release_o, long_o});
    end
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    checks++;
    if ({key_o, press_o, release_o, long_o} !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 00000000", {key_o, press_o, release_o, long_o});
    end
  endtask

  task automatic test_press_and_long;
    key_i[0] = 1'b0;
    for (int t = 1; t <= 38; t++) begin
      tick();
      if (t < 8) begin
        checks++;
        if (press_o !== 2'b00 || key_o !== 2'b00) begin
          errors++;
          $display("FAIL press_early t=%0d: press_o=%b key_o=%b expected 00/00", t, press_o, key_o);
        end
      end else if (t == 8) begin
        checks++;
        if (press_o !== 2'b01 || key_o !== 2'b01) begin
          errors++;
          $display("FAIL press_latency: press_o=%b key_o=%b expected 01/01", press_o, key_o);
        end
      end else begin
        checks++;
        if (press_o !== 2'b00 || key_o !== 2'b01 || long_o !== ((t == 18) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL long_press t=%0d: press_o=%b key_o=%b long_o=%b expected 00/01/%b",
                   t, press_o, key_o, long_o, (t == 18) ? 2'b01 : 2'b00);
        end
      end
    end
    key_i[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (release_o !== ((t == 8) ? 2'b01 : 2'b00) || key_o !== ((t == 8) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL release_latency t=%0d: release_o=%b key_o=%b expected %b/%b",
                 t, release_o, key_o, (t == 8) ? 2'b01 : 2'b00, (t == 8) ? 2'b00 : 2'b01);
      end
    end
    settle_release();
  endtask

  task automatic test_excursion(input int len, input int exp_press, input int exp_rel);
    int pt, rt, np;
    pt = 0;
    rt = 0;
    np = 0;
    key_i[0] = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (t == len) key_i[0] = 1'b1;
      if (press_o[0]) np++;
      if (press_o[0] && pt == 0) pt = t;
      if (release_o[0] && rt == 0) rt = t;
    end
    checks++;
    if (pt != exp_press || rt != exp_rel || np != (exp_press != 0 ? 1 : 0) || key_o !== 2'b00) begin
      errors++;
      $display("FAIL excursion_len%0d: press_t=%0d rel_t=%0d presses=%0d key_o=%b expected %0d/%0d/%0d/00",
               len, pt, rt, np, key_o, exp_press, exp_rel, exp_press != 0 ? 1 : 0);
    end
    settle_release();
  endtask

  task automatic test_bounce;
    int np, pt;
    np = 0;
    pt = 0;
    for (int i = 0; i < 10; i++) begin
      key_i[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (press_o[0] || key_o[0]) np++;
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL bounce_no_press: %0d pressed cycles, expected 0", np);
    end
    key_i[0] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (press_o[0]) np++;
      if (press_o[0] && pt == 0) pt = t;
    end
    checks++;
    if (np != 1 || pt != 8 || key_o !== 2'b01) begin
      errors++;
      $display("FAIL bounce_final: presses=%0d press_t=%0d key_o=%b expected 1/8/01", np, pt, key_o);
    end
    settle_release();
  endtask

  task automatic test_both_keys;
    key_i = 2'b00;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 8) begin
        checks++;
        if (press_o !== 2'b11 || key_o !== 2'b11) begin
          errors++;
          $display("FAIL both_press: press_o=%b key_o=%b expected 11/11", press_o, key_o);
        end
      end
      if (t == 18) begin
        checks++;
        if (long_o !== 2'b11) begin
          errors++;
          $display("FAIL both_long: long_o=%b expected 11", long_o);
        end
      end
    end
    key_i = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (release_o !== ((t == 8) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL both_release t=%0d: release_o=%b expected %b", t, release_o, (t == 8) ? 2'b11 : 2'b00);
      end
    end
    settle_release();
  endtask

  task automatic test_reset_mid_press;
    int nrel;
    nrel = 0;
    key_i[0] = 1'b0;
    for (int t = 1; t <= 10; t++) tick();
    checks++;
    if (key_o !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_key: key_o=%b expected 01", key_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_o, press_o, release_o, long_o} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000000", {key_o, press_o, release_o, long_o});
    end
    tick();
    if (release_o !== 2'b00) nrel++;
    tick();
    if (release_o !== 2'b00) nrel++;
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (release_o !== 2'b00) nrel++;
      checks++;
      if (press_o !== ((t == 8) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL press_after_reset t=%0d: press_o=%b expected %b", t, press_o, (t == 8) ? 2'b01 : 2'b00);
      end
    end
    checks++;
    if (nrel != 0) begin
      errors++;
      $display("FAIL reset_no_release: %0d release cycles, expected 0", nrel);
    end
    settle_release();
  endtask

  initial begin
    test_reset();
    test_press_and_long();
    test_excursion(3, 0, 0);
    test_excursion(4, 0, 0);
    test_excursion(5, 8, 13);
    test_bounce();
    test_both_keys();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
